// File: rtl/mux_rr_n_if.sv
// mux_rr_n_if: stream bundle between N producers, the mux and one consumer.
//   in_data   : N*W packed channel data, channel i at [i*W +: W]
//   in_valid  : per-channel valid from producers
//   in_ready  : per-channel ready back to producers (at most one high)
//   out_data  : selected word from the output register
//   out_ch    : index of the channel that supplied out_data
//   out_valid : output register holds a word
//   out_ready : consumer accepts out_data this cycle
// slave modport is the mux side; master modport is the producer/consumer side.
interface mux_rr_n_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_n.sv
// mux_rr_n: registered N:1 multiplexer with valid/ready handshake.
// Selects one of N W-bit channels either by explicit select (mode=0, s) or by
// round-robin among valid channels (mode=1), and holds the result in a
// one-entry output register.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   mode : 0 = manual select via s, 1 = round-robin
//   s    : channel select used when mode=0
//   bus  : stream bundle (slave side), see mux_rr_n_if
module mux_rr_n #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic [SW-1:0] s,
    mux_rr_n_if.slave     bus
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q,   out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q,      ptr_d;

    logic          load_en;
    logic          req;
    logic          grant;
    logic          found;
    logic [SW-1:0] cand;
    logic [SW-1:0] idx;

    always_comb begin
        // Output register may take a new word when empty or being drained.
        load_en = !out_valid_q || bus.out_ready;

        cand  = s;
        req   = bus.in_valid[s];
        found = 1'b0;
        idx   = '0;
        if (mode) begin
            // Scan ptr, ptr+1, ... ; SW-bit addition wraps modulo N.
            cand = ptr_q;
            req  = |bus.in_valid;
            for (int unsigned k = 0; k < N; k++) begin
                idx = ptr_q + SW'(k);
                if (!found && bus.in_valid[idx]) begin
                    cand  = idx;
                    found = 1'b1;
                end
            end
        end

        grant = req && load_en && !rst;

        bus.in_ready = '0;
        if (grant) begin
            bus.in_ready[cand] = 1'b1;
        end

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (grant) begin
            out_data_d  = bus.in_data[cand*W +: W];
            out_ch_d    = cand;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = cand + SW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed bench for mux_rr_n (W=8, N=4). Stimulus pushes the
// expected {ch,data} of every word it causes to be loaded; a monitor pops and
// compares each word when the consumer accepts it.
module tb_mux_rr_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [1:0] s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q[$];
    logic [7:0] chd [4] = '{8'h3C, 8'h5A, 8'hA5, 8'hC3};

    mux_rr_n_if #(.W(8), .N(4), .SW(2)) bus ();

    mux_rr_n #(.W(8), .N(4), .SW(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .s    (s),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string name, input logic [3:0] exp);
        #1;
        check(name, {28'd0, bus.in_ready}, {28'd0, exp});
    endtask

    task automatic push(input int ch);
        exp_q.push_back({ch[1:0], chd[ch]});
    endtask

    // Monitor: one comparison per accepted output word.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {22'd0, bus.out_ch, bus.out_data}, 32'h3FF);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("word_ch",   {30'd0, bus.out_ch},  {30'd0, e[9:8]});
                check("word_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        // Reset with all inputs active
        rst = 1'b1;
        mode = 1'b1;
        s = 2'd2;
        bus.in_data   = {chd[3], chd[2], chd[1], chd[0]};
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
            check("rst_out_ch",    {30'd0, bus.out_ch},   32'd0);
            check("rst_in_ready",  {28'd0, bus.in_ready}, 32'd0);
        end

        // Round-robin sweep: first grant after reset goes to channel 0
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_rdy("rr_in_ready", 4'b0001 << (k % 4));
            push(k % 4);
            cyc();
            check("rr_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("rr_out_ch", {30'd0, bus.out_ch}, k % 4);
        end

        // Sparse round-robin: 0,3,0,3 with pointer wrap
        bus.in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            chk_rdy("sparse_in_ready", (k % 2 == 1) ? 4'b1000 : 4'b0001);
            push((k % 2 == 1) ? 3 : 0);
            cyc();
        end

        // Manual select s=2
        mode = 1'b0;
        s = 2'd2;
        bus.in_valid = 4'b1111;
        chk_rdy("man_in_ready", 4'b0100);
        push(2);
        cyc();
        check("man_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("man_out_data",  {24'd0, bus.out_data}, 32'hA5);
        check("man_out_ch",    {30'd0, bus.out_ch},   32'd2);
        // Selected channel invalid: no transfer although others are valid
        bus.in_valid = 4'b1011;
        chk_rdy("man_inv_in_ready", 4'b0000);
        cyc();
        check("man_drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check("man_drain_data",  {24'd0, bus.out_data}, 32'hA5);
        check("man_drain_ch",    {30'd0, bus.out_ch},   32'd2);

        // Backpressure; ptr must still be 0 after manual mode
        mode = 1'b1;
        bus.in_valid = 4'b1111;
        chk_rdy("bp_first_in_ready", 4'b0001);
        push(0);
        cyc();
        bus.out_ready = 1'b0;
        chk_rdy("bp_stall_in_ready", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_data",  {24'd0, bus.out_data}, 32'h3C);
            check("bp_ch",    {30'd0, bus.out_ch},   32'd0);
            check("bp_in_ready", {28'd0, bus.in_ready}, 32'd0);
        end
        // Release: drain and load in the same cycle, ptr held at 1
        bus.out_ready = 1'b1;
        chk_rdy("bp_release_in_ready", 4'b0010);
        push(1);
        cyc();
        check("bp_reload_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_reload_data",  {24'd0, bus.out_data}, 32'h5A);
        check("bp_reload_ch",    {30'd0, bus.out_ch},   32'd1);

        // Mid-operation reset while stalled with a held word
        bus.out_ready = 1'b0;
        rst = 1'b1;
        chk_rdy("mrst_in_ready", 4'b0000);
        cyc();
        exp_q.delete(); // held word is discarded by reset
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_out_data",  {24'd0, bus.out_data}, 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk_rdy("mrst_ptr0_in_ready", 4'b0001);
        push(0);
        cyc();
        check("mrst_reload_ch", {30'd0, bus.out_ch}, 32'd0);

        // Drain remaining word and confirm every expected word was seen
        bus.in_valid = 4'b0000;
        cyc();
        check("final_out_valid", {31'd0, bus.out_valid}, 32'd0);
        cyc();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
